// File: rtl/fabric_boot_sequencer.sv
// Boot/warmboot scheduler for the fabric configuration path: drives the SPI
// controller, forwards bitstream words to fabric_config and supervises each load.
module fabric_boot_sequencer #(
  parameter int NUM_SLOTS      = 16,
  parameter int START_DELAY    = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mode_i,
  input  logic        warmboot_boot_i,
  input  logic [3:0]  warmboot_slot_i,
  output logic        warmboot_reset_o,
  output logic        ctrl_start_o,
  output logic [3:0]  ctrl_slot_o,
  input  logic        ctrl_busy_i,
  input  logic [31:0] ctrl_data_i,
  input  logic        ctrl_valid_i,
  input  logic [31:0] rx_data_i,
  input  logic        rx_valid_i,
  output logic [31:0] cfg_data_o,
  output logic        cfg_valid_o,
  input  logic        cfg_busy_i,
  input  logic        cfg_configured_i,
  output logic        busy_o,
  output logic        error_o,
  output logic [3:0]  active_slot_o
);

  // state      | meaning
  // RESET_WAIT | post-reset delay, mode sampled on last cycle
  // START      | one-cycle start pulse to the SPI controller
  // LOAD       | controller streaming, timeout running
  // CHECK      | single-cycle look at cfg_configured_i
  // IDLE       | fabric configured, waiting for warmboot
  // ERROR      | slot 0 failed, still accepts warmboot
  // RECEIVE    | receiver mode, terminal
  typedef enum logic [2:0] {
    S_RESET_WAIT,
    S_START,
    S_LOAD,
    S_CHECK,
    S_IDLE,
    S_ERROR,
    S_RECEIVE
  } state_t;

  localparam int DLY_W = $clog2(START_DELAY + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(START_DELAY - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [DLY_W-1:0] dly_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             seen_busy;
  logic             boot_q;

  logic       boot_rise;
  logic       slot_ok;
  logic       tmo_hit;
  logic       load_done;
  logic       load_fail;
  logic       in_load_phase;
  logic       start_go;
  logic [3:0] start_slot;

  assign boot_rise = warmboot_boot_i & ~boot_q;
  assign slot_ok   = ({28'd0, warmboot_slot_i} < 32'(NUM_SLOTS));
  assign tmo_hit   = (tmo_cnt == '0);
  assign load_done = seen_busy & ~ctrl_busy_i & ~cfg_busy_i;
  assign load_fail = ((state == S_LOAD) && tmo_hit) ||
                     ((state == S_CHECK) && !cfg_configured_i);

  always_comb begin
    start_go   = 1'b0;
    start_slot = 4'd0;
    if ((state == S_RESET_WAIT) && (dly_cnt == '0) && !mode_i) begin
      start_go = 1'b1;
    end else if (((state == S_IDLE) || (state == S_ERROR)) && boot_rise && slot_ok) begin
      start_go   = 1'b1;
      start_slot = warmboot_slot_i;
    end else if (load_fail && (active_slot_o != 4'd0)) begin
      start_go = 1'b1;
    end
  end

  // Receiver mode hands the fabric-side busy straight through.
  assign in_load_phase    = (state == S_RESET_WAIT) || (state == S_START) ||
                            (state == S_LOAD) || (state == S_CHECK);
  assign busy_o           = (state == S_RECEIVE) ? cfg_busy_i : in_load_phase;
  assign warmboot_reset_o = (state == S_RECEIVE) ? cfg_busy_i : in_load_phase;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= S_RESET_WAIT;
      dly_cnt       <= DLY_LOAD;
      tmo_cnt       <= TMO_LOAD;
      seen_busy     <= 1'b0;
      boot_q        <= 1'b1;
      ctrl_start_o  <= 1'b0;
      ctrl_slot_o   <= 4'd0;
      active_slot_o <= 4'd0;
      cfg_valid_o   <= 1'b0;
      cfg_data_o    <= 32'd0;
      error_o       <= 1'b0;
    end else begin
      boot_q       <= warmboot_boot_i;
      ctrl_start_o <= 1'b0;
      cfg_valid_o  <= 1'b0;

      if (state == S_LOAD) begin
        cfg_valid_o <= ctrl_valid_i;
        if (ctrl_valid_i) cfg_data_o <= ctrl_data_i;
      end else if (state == S_RECEIVE) begin
        cfg_valid_o <= rx_valid_i;
        if (rx_valid_i) cfg_data_o <= rx_data_i;
      end

      case (state)
        S_RESET_WAIT: begin
          if (dly_cnt != '0) dly_cnt <= dly_cnt - 1'b1;
          else if (mode_i)   state   <= S_RECEIVE;
        end
        S_START: begin
          seen_busy <= 1'b0;
          tmo_cnt   <= TMO_LOAD;
          state     <= S_LOAD;
        end
        S_LOAD: begin
          if (ctrl_busy_i) seen_busy <= 1'b1;
          // Timeout wins over a busy drop in the same cycle.
          if (!tmo_hit) begin
            tmo_cnt <= tmo_cnt - 1'b1;
            if (load_done) state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (cfg_configured_i) begin
            state   <= S_IDLE;
            error_o <= 1'b0;
          end
        end
        default: ;
      endcase

      if (load_fail && (active_slot_o == 4'd0)) begin
        state   <= S_ERROR;
        error_o <= 1'b1;
      end

      if (start_go) begin
        state         <= S_START;
        ctrl_start_o  <= 1'b1;
        ctrl_slot_o   <= start_slot;
        active_slot_o <= start_slot;
      end
    end
  end

endmodule

// File: tb/tb_fabric_boot_sequencer.sv
// Scenario bench for fabric_boot_sequencer: randomized bitstream words and
// slots checked against expectations derived from the boot rules.
module tb_fabric_boot_sequencer;

  localparam int NSLOT = 8;
  localparam int SDLY  = 16;
  localparam int TMO   = 64;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mode_i = 1'b0;
  logic        warmboot_boot_i = 1'b0;
  logic [3:0]  warmboot_slot_i = 4'd0;
  logic        warmboot_reset_o;
  logic        ctrl_start_o;
  logic [3:0]  ctrl_slot_o;
  logic        ctrl_busy_i = 1'b0;
  logic [31:0] ctrl_data_i = 32'd0;
  logic        ctrl_valid_i = 1'b0;
  logic [31:0] rx_data_i = 32'd0;
  logic        rx_valid_i = 1'b0;
  logic [31:0] cfg_data_o;
  logic        cfg_valid_o;
  logic        cfg_busy_i = 1'b0;
  logic        cfg_configured_i = 1'b0;
  logic        busy_o;
  logic        error_o;
  logic [3:0]  active_slot_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_data = 32'd0;

  always #5 clk_i = ~clk_i;

  fabric_boot_sequencer #(
    .NUM_SLOTS(NSLOT), .START_DELAY(SDLY), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i),
    .warmboot_boot_i(warmboot_boot_i), .warmboot_slot_i(warmboot_slot_i),
    .warmboot_reset_o(warmboot_reset_o),
    .ctrl_start_o(ctrl_start_o), .ctrl_slot_o(ctrl_slot_o),
    .ctrl_busy_i(ctrl_busy_i), .ctrl_data_i(ctrl_data_i), .ctrl_valid_i(ctrl_valid_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .cfg_data_o(cfg_data_o), .cfg_valid_o(cfg_valid_o),
    .cfg_busy_i(cfg_busy_i), .cfg_configured_i(cfg_configured_i),
    .busy_o(busy_o), .error_o(error_o), .active_slot_o(active_slot_o)
  );

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic apply_reset(input logic mode);
    rst_i = 1'b1; mode_i = mode;
    ctrl_busy_i = 0; ctrl_valid_i = 0; rx_valid_i = 0;
    cfg_busy_i = 0; cfg_configured_i = 0;
    step(); step();
    model_data = 32'd0;
  endtask

  task automatic request(input logic [3:0] slot);
    warmboot_boot_i = 1'b0;
    step();
    warmboot_slot_i = slot;
    warmboot_boot_i = 1'b1;
    step();
  endtask

  // Entered at the negedge where the START pulse should be visible; leaves at
  // the negedge just after CHECK has resolved.
  task automatic do_load(input logic [3:0] slot, input int nwords, input bit ok, input bit poke);
    int sent = 0;
    int cyc = 0;
    int hold;
    logic v;
    logic [31:0] d;
    n_checks++;
    if ({ctrl_start_o, ctrl_slot_o, active_slot_o} !== {1'b1, slot, slot}) begin
      n_fail++;
      $display("FAIL start_pulse: got start=%0b slot=%0d active=%0d, want start=1 slot=%0d active=%0d",
               ctrl_start_o, ctrl_slot_o, active_slot_o, slot, slot);
    end
    if (poke) warmboot_boot_i = 1'b0;
    ctrl_valid_i = 1'b1; ctrl_data_i = $urandom;
    step();
    n_checks++;
    if ({cfg_valid_o, cfg_data_o, ctrl_start_o, busy_o, warmboot_reset_o, ctrl_slot_o} !==
        {1'b0, model_data, 1'b0, 1'b1, 1'b1, slot}) begin
      n_fail++;
      $display("FAIL load_entry: got valid=%0b data=%h start=%0b busy=%0b wrst=%0b slot=%0d, want 0 %h 0 1 1 %0d",
               cfg_valid_o, cfg_data_o, ctrl_start_o, busy_o, warmboot_reset_o, ctrl_slot_o, model_data, slot);
    end
    ctrl_busy_i = 1'b1;
    while (sent < nwords) begin
      v = (cyc > 20) ? 1'b1 : ($urandom_range(0, 2) != 0);
      d = $urandom;
      ctrl_valid_i = v; ctrl_data_i = d;
      if (poke && cyc == 0) begin
        warmboot_slot_i = 4'($urandom_range(0, NSLOT - 1));
        warmboot_boot_i = 1'b1;
      end
      if (poke && cyc == 1) warmboot_boot_i = 1'b0;
      step();
      if (v) begin model_data = d; sent++; end
      cyc++;
      n_checks++;
      if ({cfg_valid_o, cfg_data_o} !== {v, model_data}) begin
        n_fail++;
        $display("FAIL load_word: got valid=%0b data=%h, want valid=%0b data=%h",
                 cfg_valid_o, cfg_data_o, v, model_data);
      end
    end
    if (poke) warmboot_boot_i = 1'b0;
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      ctrl_busy_i = 1'b0; cfg_busy_i = 1'b1;
      d = $urandom;
      ctrl_valid_i = 1'b1; ctrl_data_i = d;
      step();
      model_data = d;
      n_checks++;
      if ({cfg_valid_o, cfg_data_o} !== {1'b1, d}) begin
        n_fail++;
        $display("FAIL cfg_busy_hold: got valid=%0b data=%h, want valid=1 data=%h",
                 cfg_valid_o, cfg_data_o, d);
      end
    end
    ctrl_busy_i = 1'b0; cfg_busy_i = 1'b0; ctrl_valid_i = 1'b0;
    cfg_configured_i = ok;
    step();
    n_checks++;
    if ({cfg_valid_o, busy_o, ctrl_start_o, ctrl_slot_o} !== {1'b0, 1'b1, 1'b0, slot}) begin
      n_fail++;
      $display("FAIL check_cycle: got valid=%0b busy=%0b start=%0b slot=%0d, want 0 1 0 %0d",
               cfg_valid_o, busy_o, ctrl_start_o, ctrl_slot_o, slot);
    end
    ctrl_valid_i = 1'b1; ctrl_data_i = $urandom;
    step();
    ctrl_valid_i = 1'b0; cfg_configured_i = 1'b0;
    n_checks++;
    if ({cfg_valid_o, cfg_data_o} !== {1'b0, model_data}) begin
      n_fail++;
      $display("FAIL drop_outside_load: got valid=%0b data=%h, want valid=0 data=%h",
               cfg_valid_o, cfg_data_o, model_data);
    end
  endtask

  task automatic test_reset();
    warmboot_boot_i = 1'b1;
    apply_reset(1'b0);
    n_checks++;
    if ({warmboot_reset_o, busy_o, ctrl_start_o, ctrl_slot_o, cfg_valid_o, cfg_data_o, error_o, active_slot_o} !==
        {1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got wrst=%0b busy=%0b start=%0b slot=%0d valid=%0b data=%h err=%0b act=%0d",
               warmboot_reset_o, busy_o, ctrl_start_o, ctrl_slot_o, cfg_valid_o, cfg_data_o, error_o, active_slot_o);
    end
  endtask

  task automatic test_power_on();
    int cnt = 0;
    bit trig = 0;
    rst_i = 1'b0;
    while (cnt < 40 && ctrl_start_o !== 1'b1) begin
      step();
      cnt++;
    end
    n_checks++;
    if (cnt != SDLY || ctrl_start_o !== 1'b1) begin
      n_fail++;
      $display("FAIL power_on_delay: start seen after %0d cycles (start=%0b), want %0d", cnt, ctrl_start_o, SDLY);
    end
    do_load(4'd0, 3, 1'b1, 1'b0);
    n_checks++;
    if ({busy_o, warmboot_reset_o, error_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL power_on_idle: got busy=%0b wrst=%0b err=%0b, want 0 0 0", busy_o, warmboot_reset_o, error_o);
    end
    repeat (5) begin step(); if (ctrl_start_o) trig = 1; end
    n_checks++;
    if (trig) begin
      n_fail++;
      $display("FAIL boot_held_through_reset: got retrigger=1, want 0");
    end
  endtask

  task automatic test_warmboot();
    bit trig = 0;
    request(4'd5);
    do_load(4'd5, $urandom_range(1, 4), 1'b1, 1'b0);
    n_checks++;
    if ({busy_o, warmboot_reset_o, error_o, active_slot_o} !== {3'b000, 4'd5}) begin
      n_fail++;
      $display("FAIL warmboot_idle: got busy=%0b wrst=%0b err=%0b act=%0d, want 0 0 0 5",
               busy_o, warmboot_reset_o, error_o, active_slot_o);
    end
    repeat (5) begin step(); if (ctrl_start_o) trig = 1; end
    n_checks++;
    if (trig) begin
      n_fail++;
      $display("FAIL warmboot_level_retrigger: got retrigger=1, want 0");
    end
  endtask

  task automatic test_fallback();
    request(4'd7);
    do_load(4'd7, $urandom_range(1, 4), 1'b0, 1'b0);
    do_load(4'd0, $urandom_range(1, 4), 1'b0, 1'b0);
    n_checks++;
    if ({error_o, busy_o, warmboot_reset_o, ctrl_start_o} !== 4'b1000) begin
      n_fail++;
      $display("FAIL fallback_error: got err=%0b busy=%0b wrst=%0b start=%0b, want 1 0 0 0",
               error_o, busy_o, warmboot_reset_o, ctrl_start_o);
    end
    request(4'd3);
    do_load(4'd3, $urandom_range(1, 4), 1'b1, 1'b0);
    n_checks++;
    if ({error_o, busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL error_clear: got err=%0b busy=%0b, want 0 0", error_o, busy_o);
    end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    bit bad = 0;
    request(4'd2);
    ctrl_busy_i = 1'b1;
    do begin step(); cnt++; end while (cnt < 100 && ctrl_start_o !== 1'b1);
    n_checks++;
    if (cnt != TMO + 1 || ctrl_slot_o !== 4'd0 || active_slot_o !== 4'd0) begin
      n_fail++;
      $display("FAIL timeout_fallback: got restart after %0d cycles slot=%0d act=%0d, want %0d slot=0 act=0",
               cnt, ctrl_slot_o, active_slot_o, TMO + 1);
    end
    repeat (TMO) begin
      step();
      if (ctrl_start_o || error_o || !busy_o) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL timeout_early_exit: got early state change=1, want 0");
    end
    ctrl_busy_i = 1'b0; cfg_configured_i = 1'b1;
    step();
    ctrl_busy_i = 1'b0; cfg_configured_i = 1'b0;
    n_checks++;
    if ({error_o, busy_o, ctrl_start_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL timeout_priority: got err=%0b busy=%0b start=%0b, want 1 0 0", error_o, busy_o, ctrl_start_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] s;
    bit ok, final_ok, trig;
    for (int it = 0; it < 6; it++) begin
      s = 4'($urandom_range(0, NSLOT - 1));
      ok = ($urandom_range(0, 3) != 0);
      request(s);
      do_load(s, $urandom_range(1, 4), ok, 1'b1);
      final_ok = ok;
      if (!ok && s != 4'd0) begin
        final_ok = ($urandom_range(0, 1) != 0);
        do_load(4'd0, $urandom_range(1, 4), final_ok, 1'b1);
      end
      n_checks++;
      if ({error_o, busy_o} !== {!final_ok, 1'b0}) begin
        n_fail++;
        $display("FAIL b2b_outcome: iter %0d slot %0d got err=%0b busy=%0b, want err=%0b busy=0",
                 it, s, error_o, busy_o, !final_ok);
      end
      trig = 0;
      repeat (3) begin step(); if (ctrl_start_o) trig = 1; end
      n_checks++;
      if (trig) begin
        n_fail++;
        $display("FAIL b2b_not_queued: iter %0d got start=1, want 0", it);
      end
    end
  endtask

  task automatic test_invalid_slot();
    logic [3:0] bad_slots [3];
    bit trig;
    bad_slots[0] = 4'd15;
    bad_slots[1] = 4'(NSLOT);
    bad_slots[2] = 4'($urandom_range(NSLOT, 15));
    for (int i = 0; i < 3; i++) begin
      request(bad_slots[i]);
      trig = (ctrl_start_o === 1'b1);
      repeat (3) begin step(); if (ctrl_start_o || busy_o) trig = 1; end
      n_checks++;
      if (trig) begin
        n_fail++;
        $display("FAIL invalid_slot: slot %0d got accepted=1, want 0", bad_slots[i]);
      end
    end
    request(4'(NSLOT - 1));
    do_load(4'(NSLOT - 1), $urandom_range(1, 4), 1'b1, 1'b0);
    n_checks++;
    if ({error_o, busy_o, active_slot_o} !== {2'b00, 4'(NSLOT - 1)}) begin
      n_fail++;
      $display("FAIL top_slot_load: got err=%0b busy=%0b act=%0d, want 0 0 %0d",
               error_o, busy_o, active_slot_o, NSLOT - 1);
    end
  endtask

  task automatic test_reset_mid_load();
    request(4'd1);
    step();
    ctrl_busy_i = 1'b1;
    ctrl_valid_i = 1'b1; ctrl_data_i = $urandom | 32'h1;
    step();
    n_checks++;
    if (cfg_valid_o !== 1'b1 || cfg_data_o === 32'd0) begin
      n_fail++;
      $display("FAIL pre_reset_word: got valid=%0b data=%h, want valid=1 nonzero data", cfg_valid_o, cfg_data_o);
    end
    ctrl_data_i = $urandom;
    rst_i = 1'b1;
    step();
    n_checks++;
    if ({warmboot_reset_o, busy_o, ctrl_start_o, ctrl_slot_o, cfg_valid_o, cfg_data_o, error_o, active_slot_o} !==
        {1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL mid_load_reset: got wrst=%0b busy=%0b start=%0b slot=%0d valid=%0b data=%h err=%0b act=%0d",
               warmboot_reset_o, busy_o, ctrl_start_o, ctrl_slot_o, cfg_valid_o, cfg_data_o, error_o, active_slot_o);
    end
    ctrl_valid_i = 1'b0; ctrl_busy_i = 1'b0;
    model_data = 32'd0;
  endtask

  task automatic test_receive();
    bit trig = 0;
    logic rv, cv, cb;
    logic [31:0] rd;
    warmboot_boot_i = 1'b0;
    apply_reset(1'b1);
    rst_i = 1'b0;
    step();
    n_checks++;
    if ({busy_o, warmboot_reset_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL rx_reset_wait: got busy=%0b wrst=%0b, want 1 1", busy_o, warmboot_reset_o);
    end
    repeat (SDLY + 4) begin step(); if (ctrl_start_o) trig = 1; end
    mode_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rv = $urandom_range(0, 1); rd = $urandom;
      cv = $urandom_range(0, 1); cb = $urandom_range(0, 1);
      rx_valid_i = rv; rx_data_i = rd;
      ctrl_valid_i = cv; ctrl_data_i = $urandom;
      if (i == 10) begin warmboot_slot_i = 4'd4; warmboot_boot_i = 1'b1; end
      step();
      if (rv) model_data = rd;
      if (ctrl_start_o) trig = 1;
      n_checks++;
      if ({cfg_valid_o, cfg_data_o} !== {rv, model_data}) begin
        n_fail++;
        $display("FAIL rx_word: iter %0d got valid=%0b data=%h, want valid=%0b data=%h",
                 i, cfg_valid_o, cfg_data_o, rv, model_data);
      end
      cfg_busy_i = cb;
      #1;
      n_checks++;
      if ({busy_o, warmboot_reset_o} !== {cb, cb}) begin
        n_fail++;
        $display("FAIL rx_busy_follow: iter %0d got busy=%0b wrst=%0b, want %0b %0b",
                 i, busy_o, warmboot_reset_o, cb, cb);
      end
    end
    rx_valid_i = 1'b0; ctrl_valid_i = 1'b0; cfg_busy_i = 1'b0;
    n_checks++;
    if (trig || active_slot_o !== 4'd0) begin
      n_fail++;
      $display("FAIL rx_no_start: got start seen=%0b act=%0d, want 0 0", trig, active_slot_o);
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_warmboot();
    test_fallback();
    test_timeout();
    test_back_to_back();
    test_invalid_slot();
    test_reset_mid_load();
    test_receive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
